sad_row_min: RTL and testbench

- Stage directly upstream of the motion-estimation post processor.
- Each cycle it may accept one row of 16 candidate SADs from the PE array.
- It reduces each row to its minimum SAD and column index through a 4-level registered comparator tree, and tags the result with the row number.
- It drives the post processor's MSAD_interim, MSAD_index_interim, current_row and en inputs, and sequences one search window of NUM_ROWS rows per start.

---
 rtl/sad_row_min_pkg.sv | 25 ++
 rtl/sad_row_min_if.sv | 26 ++
 rtl/sad_min_node.sv | 33 +++
 rtl/sad_row_min.sv | 166 ++++++++++++++++
 tb/tb_sad_row_min.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sad_row_min_pkg.sv
// Shared types and constants for the SAD row-minimum stage.
// The comparator tree carries {sad, idx} pairs sized by SAD_W.
package sad_row_min_pkg;

  localparam int unsigned NUM_COLS  = 16;
  localparam int unsigned COL_IDX_W = 4;
  localparam int unsigned SAD_W     = 14;
  localparam int unsigned ROW_W     = 5;

  typedef struct packed {
    logic [SAD_W-1:0]     sad;
    logic [COL_IDX_W-1:0] idx;
  } cand_t;

  // All-ones SAD never wins the post processor's strict compare.
  localparam cand_t CAND_IDLE = '{sad: '1, idx: '0};

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/sad_row_min_if.sv
// Row input from the PE array and interim outputs toward the post processor.
interface sad_row_min_if #(
  parameter int unsigned SAD_BIT_WIDTH = 14
);

  logic                                                start;
  logic                                                sad_valid;
  logic [sad_row_min_pkg::NUM_COLS*SAD_BIT_WIDTH-1:0]  sad_in;
  logic [SAD_BIT_WIDTH-1:0]                            MSAD_interim;
  logic [sad_row_min_pkg::COL_IDX_W-1:0]               MSAD_index_interim;
  logic [sad_row_min_pkg::ROW_W-1:0]                   current_row;
  logic                                                en;
  logic                                                done;
  logic                                                err;

  modport master (
    output start, sad_valid, sad_in,
    input  MSAD_interim, MSAD_index_interim, current_row, en, done, err
  );

  modport slave (
    input  start, sad_valid, sad_in,
    output MSAD_interim, MSAD_index_interim, current_row, en, done, err
  );

endinterface

// File: rtl/sad_min_node.sv
// One registered 2-input minimum; ties go to the left (lower column) operand.
// Loads the idle candidate when its inputs are not valid.
module sad_min_node
  import sad_row_min_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  vld,
  input  cand_t a,
  input  cand_t b,
  output cand_t y
);

  cand_t y_d, y_q;

  always_comb begin
    y_d = CAND_IDLE;
    if (vld) begin
      y_d = (b.sad < a.sad) ? b : a;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q <= CAND_IDLE;
    end else begin
      y_q <= y_d;
    end
  end

  assign y = y_q;

endmodule

// File: rtl/sad_row_min.sv
// Reduces each 16-column SAD row to its minimum and column index through a
// 4-level registered tree, and sequences one search window per start.
module sad_row_min
  import sad_row_min_pkg::*;
#(
  parameter int unsigned SAD_BIT_WIDTH = SAD_W,
  parameter int unsigned NUM_ROWS      = 17
) (
  input  logic          clk,
  input  logic          rst_n,
  sad_row_min_if.slave  bus
);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);

  state_e           state_q, state_d;
  logic [ROW_W-1:0] in_row_q, in_row_d;
  logic             err_q, err_d;
  logic             en_q, done_q;
  logic             accept;

  // vld_q[k] / tag_q[k] travel alongside tree level k+1.
  logic [3:0]       vld_q;
  logic [ROW_W-1:0] tag_q [4];

  cand_t leaf [NUM_COLS];
  cand_t lvl1 [8];
  cand_t lvl2 [4];
  cand_t lvl3 [2];
  cand_t lvl4;

  assign accept = (state_q == StRun) && bus.sad_valid;

  for (genvar c = 0; c < NUM_COLS; c++) begin : g_leaf
    assign leaf[c] = '{sad: bus.sad_in[c*SAD_BIT_WIDTH +: SAD_BIT_WIDTH],
                       idx: COL_IDX_W'(c)};
  end

  for (genvar i = 0; i < 8; i++) begin : g_l1
    sad_min_node u_node (
      .clk   (clk),
      .rst_n (rst_n),
      .vld   (accept),
      .a     (leaf[2*i]),
      .b     (leaf[2*i+1]),
      .y     (lvl1[i])
    );
  end

  for (genvar i = 0; i < 4; i++) begin : g_l2
    sad_min_node u_node (
      .clk   (clk),
      .rst_n (rst_n),
      .vld   (vld_q[0]),
      .a     (lvl1[2*i]),
      .b     (lvl1[2*i+1]),
      .y     (lvl2[i])
    );
  end

  for (genvar i = 0; i < 2; i++) begin : g_l3
    sad_min_node u_node (
      .clk   (clk),
      .rst_n (rst_n),
      .vld   (vld_q[1]),
      .a     (lvl2[2*i]),
      .b     (lvl2[2*i+1]),
      .y     (lvl3[i])
    );
  end

  sad_min_node u_l4 (
    .clk   (clk),
    .rst_n (rst_n),
    .vld   (vld_q[2]),
    .a     (lvl3[0]),
    .b     (lvl3[1]),
    .y     (lvl4)
  );

  // Tags only advance with valid data so current_row holds across gaps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int k = 0; k < 4; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      vld_q <= {vld_q[2:0], accept};
      if (accept) begin
        tag_q[0] <= in_row_q;
      end
      for (int k = 1; k < 4; k++) begin
        if (vld_q[k-1]) begin
          tag_q[k] <= tag_q[k-1];
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    in_row_d = in_row_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d  = StRun;
          in_row_d = '0;
          err_d    = 1'b0;
        end
      end
      StRun: begin
        if (bus.start) begin
          err_d = 1'b1;
        end
        if (bus.sad_valid) begin
          if (in_row_q == LAST_ROW) begin
            state_d = StDrain;
          end else begin
            in_row_d = in_row_q + 1'b1;
          end
        end
      end
      StDrain: begin
        if (bus.start || bus.sad_valid) begin
          err_d = 1'b1;
        end
        if (vld_q[3] && (tag_q[3] == LAST_ROW)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (bus.start) begin
          err_d = 1'b1;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      in_row_q <= '0;
      err_q    <= 1'b0;
      en_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      in_row_q <= in_row_d;
      err_q    <= err_d;
      en_q     <= (state_d != StIdle);
      done_q   <= (state_d == StDone);
    end
  end

  assign bus.MSAD_interim       = lvl4.sad;
  assign bus.MSAD_index_interim = lvl4.idx;
  assign bus.current_row        = tag_q[3];
  assign bus.en                 = en_q;
  assign bus.done               = done_q;
  assign bus.err                = err_q;

endmodule

// File: tb/tb_sad_row_min.sv
// Self-checking bench for sad_row_min: per-row scoreboard plus a small
// post-processor model tracking the window minimum while en is high.
module tb_sad_row_min;

  localparam int unsigned SW = 14;
  localparam int unsigned NR = 17;
  localparam logic [SW-1:0] ALL1 = '1;

  typedef struct {
    logic [SW-1:0] sad;
    logic [3:0]    idx;
    logic [4:0]    row;
    int            cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  sad_row_min_if #(.SAD_BIT_WIDTH(SW)) bus ();

  sad_row_min #(
    .SAD_BIT_WIDTH (SW),
    .NUM_ROWS      (NR)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  exp_t sb[$];

  logic [SW-1:0] pp_msad;
  logic [3:0]    pp_idx;
  logic [4:0]    pp_row;
  logic [SW-1:0] g_min;
  logic [3:0]    g_idx;
  logic [4:0]    g_row;
  bit  done_seen, in_window, en_dropped, err_at_start;
  int  done_cyc, done_cnt, last_acc;

  function automatic logic [16*SW-1:0] make_row(input int r, input int kind);
    logic [16*SW-1:0] v;
    int s;
    v = '0;
    for (int c = 0; c < 16; c++) begin
      case (kind)
        0:       s = (r == 9 && c == 5) ? 37 : 1000 + c;
        1:       s = (r % 2 == 0) ? 200 : ((c == 3 || c == 12) ? 50 : 900);
        2:       s = 3000 - r * 40 + ((c * 5 + r * 3 + 7) % 16) * 10;
        default: s = 1;
      endcase
      v[c*SW +: SW] = SW'(s);
    end
    return v;
  endfunction

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (!bus.en) begin
      pp_msad = ALL1; pp_idx = '0; pp_row = '0;
    end else if (bus.MSAD_interim < pp_msad) begin
      pp_msad = bus.MSAD_interim; pp_idx = bus.MSAD_index_interim; pp_row = bus.current_row;
    end
    if (in_window && !bus.en) en_dropped = 1'b1;
    if (bus.done) begin
      done_seen = 1'b1; done_cyc = cyc; done_cnt++;
    end
    if (bus.MSAD_interim !== ALL1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got sad=%0d idx=%0d row=%0d at cycle %0d, required none",
                 bus.MSAD_interim, bus.MSAD_index_interim, bus.current_row, cyc);
      end else begin
        e = sb.pop_front();
        if (bus.MSAD_interim !== e.sad || bus.MSAD_index_interim !== e.idx ||
            bus.current_row !== e.row || cyc != e.cyc) begin
          errors++;
          $display("FAIL row_result: got sad=%0d idx=%0d row=%0d cyc=%0d, required sad=%0d idx=%0d row=%0d cyc=%0d",
                   bus.MSAD_interim, bus.MSAD_index_interim, bus.current_row, cyc,
                   e.sad, e.idx, e.row, e.cyc);
        end
      end
    end else begin
      checks++;
      if (bus.MSAD_index_interim !== 4'd0) begin
        errors++;
        $display("FAIL idle_index: got %0d, required 0 at cycle %0d", bus.MSAD_index_interim, cyc);
      end
      if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_result: no result at cycle %0d, required sad=%0d row=%0d",
                 cyc, sb[0].sad, sb[0].row);
        void'(sb.pop_front());
      end
    end
  endtask

  task automatic drive_row(input logic [16*SW-1:0] row, input bit acc, input int r);
    logic [SW-1:0] m;
    logic [3:0]    ix;
    bus.sad_valid = 1'b1;
    bus.sad_in    = row;
    tick();
    bus.sad_valid = 1'b0;
    if (acc) begin
      m = ALL1; ix = '0;
      for (int c = 0; c < 16; c++) begin
        if (row[c*SW +: SW] < m) begin
          m = row[c*SW +: SW]; ix = 4'(c);
        end
      end
      sb.push_back('{sad: m, idx: ix, row: 5'(r), cyc: cyc + 3});
      if (m < g_min) begin
        g_min = m; g_idx = ix; g_row = 5'(r);
      end
      last_acc = cyc;
    end
  endtask

  task automatic run_window(input int kind, input int gap, input bit extra_start,
                            input bit drain_valid);
    g_min = ALL1; g_idx = '0; g_row = '0;
    done_seen = 1'b0; en_dropped = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    in_window = 1'b1;
    err_at_start = bus.err;
    checks++;
    if (bus.en !== 1'b1) begin
      errors++;
      $display("FAIL en_after_start: got %b, required 1", bus.en);
    end
    for (int r = 0; r < NR; r++) begin
      if (extra_start && r == 5) bus.start = 1'b1;
      drive_row(make_row(r, kind), 1'b1, r);
      bus.start = 1'b0;
      for (int g = 0; g < gap; g++) tick();
    end
    if (drain_valid) drive_row(make_row(0, 9), 1'b0, 0);
    for (int n = 0; n < 40 && !done_seen; n++) tick();
    in_window = 1'b0;
    checks++;
    if (!done_seen) begin
      errors++;
      $display("FAIL done_timeout: got no done within 40 cycles, required one");
    end else begin
      checks++;
      if (done_cyc != last_acc + 4) begin
        errors++;
        $display("FAIL done_cycle: got %0d, required %0d", done_cyc, last_acc + 4);
      end
      checks++;
      if (en_dropped) begin
        errors++;
        $display("FAIL en_window: got en low inside window, required en high throughout");
      end
      checks++;
      if (pp_msad !== g_min || pp_idx !== g_idx || pp_row !== g_row) begin
        errors++;
        $display("FAIL pp_result: got msad=%0d col=%0d row=%0d, required msad=%0d col=%0d row=%0d",
                 pp_msad, pp_idx, pp_row, g_min, g_idx, g_row);
      end
    end
    tick();
    checks++;
    if (bus.en !== 1'b0 || bus.done !== 1'b0 || bus.current_row !== 5'(NR - 1)) begin
      errors++;
      $display("FAIL after_done: got en=%b done=%b row=%0d, required en=0 done=0 row=%0d",
               bus.en, bus.done, bus.current_row, NR - 1);
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #2;
    checks++;
    if (bus.en !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0 ||
        bus.MSAD_interim !== ALL1 || bus.MSAD_index_interim !== 4'd0 ||
        bus.current_row !== 5'd0) begin
      errors++;
      $display("FAIL reset_state: got en=%b done=%b err=%b msad=%0h idx=%0d row=%0d, required 0 0 0 %0h 0 0",
               bus.en, bus.done, bus.err, bus.MSAD_interim, bus.MSAD_index_interim,
               bus.current_row, ALL1);
    end
    tick();
    tick();
    rst_n = 1'b1;
    bus.sad_valid = 1'b1;
    bus.sad_in    = make_row(0, 0);
    tick();
    tick();
    bus.sad_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (bus.en !== 1'b0) begin
      errors++;
      $display("FAIL idle_ignores_valid: got en=%b, required 0", bus.en);
    end
  endtask

  task automatic test_main_window();
    run_window(0, 0, 1'b0, 1'b0);
    checks++;
    if (bus.err !== 1'b0) begin
      errors++;
      $display("FAIL main_err: got %b, required 0", bus.err);
    end
  endtask

  task automatic test_ties();
    run_window(1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_gaps();
    run_window(0, 2, 1'b0, 1'b0);
  endtask

  task automatic test_err();
    run_window(0, 0, 1'b1, 1'b1);
    tick();
    tick();
    checks++;
    if (bus.err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: got %b, required 1", bus.err);
    end
    run_window(2, 0, 1'b0, 1'b0);
    checks++;
    if (err_at_start !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: got %b after start, required 0", err_at_start);
    end
  endtask

  task automatic test_reset_mid_run();
    int dc;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int r = 0; r < 6; r++) drive_row(make_row(r, 2), 1'b1, r);
    #2 rst_n = 1'b0;
    #1;
    sb.delete();
    checks++;
    if (bus.en !== 1'b0 || bus.MSAD_interim !== ALL1) begin
      errors++;
      $display("FAIL mid_reset: got en=%b msad=%0h, required en=0 msad=%0h",
               bus.en, bus.MSAD_interim, ALL1);
    end
    dc = done_cnt;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (done_cnt != dc) begin
      errors++;
      $display("FAIL no_done_after_reset: got %0d done pulses, required 0", done_cnt - dc);
    end
    run_window(0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_window(2, 0, 1'b0, 1'b0);
    run_window(1, 0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.sad_valid = 1'b0;
    bus.sad_in    = '0;
    pp_msad = ALL1; pp_idx = '0; pp_row = '0;
    done_cnt = 0; in_window = 1'b0;
    test_reset();
    test_main_window();
    test_ties();
    test_gaps();
    test_err();
    test_reset_mid_run();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
